// File: rtl/bounce_seq_ctrl.sv
// -----------------------------------------------------------------------------
// bounce_seq_ctrl
//
// Sequencer for a bounded up/down ("bounce") counter. It holds a programmable
// lower bound, upper bound and step, and sweeps the count lo -> hi -> lo for a
// programmed number of sweeps (0 = forever). It supports pause and abort and
// reports busy/done.
//
// Handshake: a config transfer happens on a rising edge where
// cfg_valid & cfg_ready are both high. cfg_ready is high only in IDLE, so
// cfg_valid outside IDLE is simply not consumed. The master may hold
// cfg_valid and its payload for as long as it likes; there is no backpressure
// beyond cfg_ready.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   cfg_valid/ready   config handshake (ready high iff IDLE)
//   cfg_lo/hi/step    bounds and step magnitude (accepted if lo<hi, step!=0)
//   cfg_sweeps        sweeps to run, 0 = run forever
//   cfg_err           one-cycle pulse when a transferred config is rejected
//   start             begin a sequence (IDLE only)
//   pause             hold all state while high (RUN only)
//   stop              abort to IDLE, count/dir/sweep_cnt hold
//   cnt_out, dir      current count, 1 = counting up
//   busy              high in RUN
//   done              one-cycle pulse after the programmed sweeps complete
//   sweep_cnt         completed sweeps (wraps)
//   state_dbg         FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module bounce_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int SW_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_lo,
   input  logic [WIDTH-1:0] cfg_hi,
   input  logic [WIDTH-1:0] cfg_step,
   input  logic [SW_W-1:0]  cfg_sweeps,
   output logic             cfg_err,
   input  logic             start,
   input  logic             pause,
   input  logic             stop,
   output logic [WIDTH-1:0] cnt_out,
   output logic             dir,
   output logic             busy,
   output logic             done,
   output logic [SW_W-1:0]  sweep_cnt,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d, step_q, step_d;
   logic [SW_W-1:0]  sweeps_q, sweeps_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic [SW_W-1:0]  sw_q, sw_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             cfg_xfer;
   logic             cfg_ok;
   logic [WIDTH:0]   up_sum;    // one extra bit so cnt+step cannot wrap
   logic [WIDTH:0]   lo_plus;   // lo+step, same reason
   logic [SW_W-1:0]  sw_inc;

   assign cfg_ready = (state_q == S_IDLE);
   assign cfg_xfer  = cfg_valid & cfg_ready;
   assign cfg_ok    = (cfg_lo < cfg_hi) && (cfg_step != '0);
   assign up_sum    = {1'b0, cnt_q} + {1'b0, step_q};
   assign lo_plus   = {1'b0, lo_q} + {1'b0, step_q};
   assign sw_inc    = sw_q + SW_W'(1);

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      step_d   = step_q;
      sweeps_d = sweeps_q;
      cnt_d    = cnt_q;
      dir_d    = dir_q;
      sw_d     = sw_q;
      done_d   = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            // A config transfer in the same cycle wins over start.
            if (cfg_xfer) begin
               if (cfg_ok) begin
                  lo_d     = cfg_lo;
                  hi_d     = cfg_hi;
                  step_d   = cfg_step;
                  sweeps_d = cfg_sweeps;
               end else begin
                  err_d = 1'b1;
               end
            end else if (start) begin
               cnt_d   = lo_q;
               dir_d   = 1'b1;
               sw_d    = '0;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (pause) begin
               // everything holds
            end else if (dir_q) begin
               // Clamp at hi so the upper bound is always visited.
               if (up_sum >= {1'b0, hi_q}) begin
                  cnt_d = hi_q;
                  dir_d = 1'b0;
               end else begin
                  cnt_d = up_sum[WIDTH-1:0];
               end
            end else begin
               // Comparing against lo+step avoids computing cnt-step below 0.
               if ({1'b0, cnt_q} <= lo_plus) begin
                  cnt_d = lo_q;
                  dir_d = 1'b1;
                  sw_d  = sw_inc;
                  if ((sweeps_q != '0) && (sw_inc == sweeps_q)) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q - step_q;
               end
            end
         end

         S_DONE: begin
            // cnt is already lo and dir already up from the finishing edge.
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         lo_q     <= '0;
         hi_q     <= '1;
         step_q   <= WIDTH'(1);
         sweeps_q <= '0;
         cnt_q    <= '0;
         dir_q    <= 1'b1;
         sw_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         step_q   <= step_d;
         sweeps_q <= sweeps_d;
         cnt_q    <= cnt_d;
         dir_q    <= dir_d;
         sw_q     <= sw_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign cnt_out   = cnt_q;
   assign dir       = dir_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign sweep_cnt = sw_q;
   assign cfg_err   = err_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_bounce_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bounce_seq_ctrl
//
// Directed bench for bounce_seq_ctrl. Expected output vectors are pushed into
// a queue as each step is driven and popped when the DUT output for that
// step is sampled, one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_bounce_seq_ctrl;

   localparam int WIDTH = 4;
   localparam int SW_W  = 8;
   localparam int PW    = WIDTH + 3 + SW_W;
   localparam int ST_IDLE = 0;
   localparam int ST_RUN  = 1;
   localparam int ST_DONE = 2;

   // ---------------------------------------------------------------- clock/reset
   logic clk;
   logic rst_n;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic             cfg_valid, cfg_ready, cfg_err;
   logic [WIDTH-1:0] cfg_lo, cfg_hi, cfg_step;
   logic [SW_W-1:0]  cfg_sweeps;
   logic             start, pause, stop;
   logic [WIDTH-1:0] cnt_out;
   logic             dir, busy, done;
   logic [SW_W-1:0]  sweep_cnt;
   logic [1:0]       state_dbg;

   bounce_seq_ctrl #(.WIDTH(WIDTH), .SW_W(SW_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_lo     (cfg_lo),
      .cfg_hi     (cfg_hi),
      .cfg_step   (cfg_step),
      .cfg_sweeps (cfg_sweeps),
      .cfg_err    (cfg_err),
      .start      (start),
      .pause      (pause),
      .stop       (stop),
      .cnt_out    (cnt_out),
      .dir        (dir),
      .busy       (busy),
      .done       (done),
      .sweep_cnt  (sweep_cnt),
      .state_dbg  (state_dbg)
   );

   // ---------------------------------------------------------------- scoreboard
   int errors = 0;
   int checks = 0;
   logic [PW-1:0] exp_q[$];
   string         tag_q[$];

   // Reference model state
   int m_lo, m_hi, m_step, m_sweeps;
   int m_cnt, m_dir, m_sw, m_state, m_done;

   function automatic logic [PW-1:0] pack(int c, int d, int b, int dn, int s);
      return {c[WIDTH-1:0], d[0], b[0], dn[0], s[SW_W-1:0]};
   endfunction

   task automatic model_reset();
      m_lo = 0; m_hi = 15; m_step = 1; m_sweeps = 0;
      m_cnt = 0; m_dir = 1; m_sw = 0; m_state = ST_IDLE; m_done = 0;
   endtask

   task automatic model_start();
      m_cnt = m_lo; m_dir = 1; m_sw = 0; m_state = ST_RUN; m_done = 0;
   endtask

   task automatic model_stop();
      m_state = ST_IDLE;
   endtask

   task automatic model_cfg(int lo, int hi, int step, int sweeps);
      m_lo = lo; m_hi = hi; m_step = step; m_sweeps = sweeps;
   endtask

   // One counting edge, no pause/stop.
   task automatic model_count();
      if (m_state == ST_DONE) begin
         m_state = ST_IDLE;
         m_done  = 0;
      end else if (m_state == ST_RUN) begin
         if (m_dir == 1) begin
            if (m_cnt + m_step >= m_hi) begin
               m_cnt = m_hi;
               m_dir = 0;
            end else begin
               m_cnt = m_cnt + m_step;
            end
         end else begin
            if (m_cnt - m_step <= m_lo) begin
               m_cnt = m_lo;
               m_dir = 1;
               m_sw  = (m_sw + 1) % 256;
               if (m_sweeps != 0 && m_sw == m_sweeps) begin
                  m_state = ST_DONE;
                  m_done  = 1;
               end
            end else begin
               m_cnt = m_cnt - m_step;
            end
         end
      end
   endtask

   task automatic push_model(string tag);
      exp_q.push_back(pack(m_cnt, m_dir, (m_state == ST_RUN) ? 1 : 0, m_done, m_sw));
      tag_q.push_back(tag);
   endtask

   task automatic compare_out();
      logic [PW-1:0] o;
      logic [PW-1:0] e;
      string t;
      o = {cnt_out, dir, busy, done, sweep_cnt};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL sb_empty observed=%0h expected=<none>", o);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (o === e) else begin
            errors++;
            $error("FAIL %s observed cnt=%0d dir=%0b busy=%0b done=%0b sw=%0d expected cnt=%0d dir=%0b busy=%0b done=%0b sw=%0d",
                   t, o[PW-1 -: WIDTH], o[SW_W+2], o[SW_W+1], o[SW_W], o[SW_W-1:0],
                   e[PW-1 -: WIDTH], e[SW_W+2], e[SW_W+1], e[SW_W], e[SW_W-1:0]);
         end
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // ---------------------------------------------------------------- drivers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(string tag);
      model_count();
      push_model(tag);
      tick();
      compare_out();
   endtask

   task automatic drive_cfg(int lo, int hi, int step, int sweeps);
      cfg_lo     = WIDTH'(lo);
      cfg_hi     = WIDTH'(hi);
      cfg_step   = WIDTH'(step);
      cfg_sweeps = SW_W'(sweeps);
      cfg_valid  = 1'b1;
   endtask

   // ---------------------------------------------------------------- watchdog
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------- stimulus
   int seq_t2 [13] = '{3, 7, 11, 12, 8, 4, 3, 7, 11, 12, 8, 4, 3};

   initial begin
      int guard;
      int d, s;
      rst_n = 1'b0; cfg_valid = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
      cfg_lo = '0; cfg_hi = '0; cfg_step = '0; cfg_sweeps = '0;
      model_reset();
      #12;
      push_model("reset");
      compare_out();
      chk("reset_ready", cfg_ready, 1);
      chk("reset_err", cfg_err, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: default config, free-running bounce
      start = 1'b1;
      model_start();
      push_model("t1_load");
      tick();
      start = 1'b0;
      compare_out();
      for (int i = 0; i < 40; i++) cyc("t1_run");
      chk("t1_sweep_cnt", sweep_cnt, 1);
      stop = 1'b1;
      model_stop();
      push_model("t1_stop");
      tick();
      stop = 1'b0;
      compare_out();
      chk("t1_ready", cfg_ready, 1);

      // 2: lo=3 hi=12 step=4 sweeps=2
      drive_cfg(3, 12, 4, 2);
      model_cfg(3, 12, 4, 2);
      push_model("t2_cfg");
      tick();
      cfg_valid = 1'b0;
      compare_out();
      chk("t2_err", cfg_err, 0);
      start = 1'b1;
      for (int i = 0; i < 13; i++) begin
         d = (seq_t2[i] == 12 || seq_t2[i] == 8 || seq_t2[i] == 4) ? 0 : 1;
         s = (i < 6) ? 0 : ((i < 12) ? 1 : 2);
         exp_q.push_back(pack(seq_t2[i], d, (i == 12) ? 0 : 1, (i == 12) ? 1 : 0, s));
         tag_q.push_back("t2_seq");
         tick();
         start = 1'b0;
         compare_out();
      end
      exp_q.push_back(pack(3, 1, 0, 0, 2));
      tag_q.push_back("t2_idle");
      tick();
      compare_out();
      chk("t2_ready", cfg_ready, 1);
      m_cnt = 3; m_dir = 1; m_sw = 2; m_state = ST_IDLE; m_done = 0;

      // 3: rejected configs, then default bounds
      rst_n = 1'b0;
      #1;
      model_reset();
      push_model("t3_rst");
      compare_out();
      @(negedge clk);
      rst_n = 1'b1;
      drive_cfg(9, 9, 1, 0);
      push_model("t3_rej_eq");
      tick();
      cfg_valid = 1'b0;
      compare_out();
      chk("t3_err_pulse", cfg_err, 1);
      push_model("t3_rej_eq_after");
      tick();
      compare_out();
      chk("t3_err_clear", cfg_err, 0);
      drive_cfg(2, 5, 0, 0);
      push_model("t3_rej_step");
      tick();
      cfg_valid = 1'b0;
      compare_out();
      chk("t3_err_step_pulse", cfg_err, 1);
      tick();
      chk("t3_err_step_clear", cfg_err, 0);
      start = 1'b1;
      model_start();
      push_model("t3_load");
      tick();
      start = 1'b0;
      compare_out();
      for (int i = 0; i < 20; i++) cyc("t3_run");
      stop = 1'b1;
      model_stop();
      push_model("t3_stop");
      tick();
      stop = 1'b0;
      compare_out();

      // 4: pause, then pause+stop together
      start = 1'b1;
      model_start();
      push_model("t4_load");
      tick();
      start = 1'b0;
      compare_out();
      for (int i = 0; i < 6; i++) cyc("t4_up");
      pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
         push_model("t4_pause");
         tick();
         compare_out();
      end
      pause = 1'b0;
      cyc("t4_resume");
      chk("t4_resume_val", cnt_out, 7);
      guard = 0;
      while (!(m_cnt == 6 && m_dir == 0) && guard < 40) begin
         cyc("t4_run");
         guard++;
      end
      pause = 1'b1;
      stop  = 1'b1;
      model_stop();
      push_model("t4_pause_stop");
      tick();
      pause = 1'b0;
      stop  = 1'b0;
      compare_out();
      chk("t4_hold6", cnt_out, 6);
      chk("t4_state", state_dbg, ST_IDLE);

      // 5: asynchronous reset mid-run, bounds restored
      drive_cfg(2, 13, 1, 0);
      model_cfg(2, 13, 1, 0);
      push_model("t5_cfg");
      tick();
      cfg_valid = 1'b0;
      compare_out();
      start = 1'b1;
      model_start();
      push_model("t5_load");
      tick();
      start = 1'b0;
      compare_out();
      for (int i = 0; i < 8; i++) cyc("t5_up");
      chk("t5_at10", cnt_out, 10);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      push_model("t5_async");
      compare_out();
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      model_start();
      push_model("t5_reload");
      tick();
      start = 1'b0;
      compare_out();
      for (int i = 0; i < 16; i++) cyc("t5_default_bounds");
      stop = 1'b1;
      model_stop();
      push_model("t5_stop");
      tick();
      stop = 1'b0;
      compare_out();

      // 6: cfg and start together; cfg during run; start/stop in DONE
      drive_cfg(1, 4, 1, 1);
      start = 1'b1;
      model_cfg(1, 4, 1, 1);
      push_model("t6_cfg_start");
      tick();
      cfg_valid = 1'b0;
      start = 1'b0;
      compare_out();
      chk("t6_no_run", state_dbg, ST_IDLE);
      start = 1'b1;
      model_start();
      push_model("t6_load");
      tick();
      start = 1'b0;
      compare_out();
      cyc("t6_up");
      drive_cfg(0, 15, 3, 0);
      chk("t6_ready_low", cfg_ready, 0);
      cyc("t6_cfg_in_run");
      chk("t6_no_err_a", cfg_err, 0);
      cyc("t6_cfg_in_run");
      chk("t6_no_err_b", cfg_err, 0);
      cfg_valid = 1'b0;
      cyc("t6_down");
      cyc("t6_down");
      cyc("t6_done");
      chk("t6_done_state", state_dbg, ST_DONE);
      start = 1'b1;
      stop  = 1'b1;
      cyc("t6_after_done");
      start = 1'b0;
      stop  = 1'b0;
      chk("t6_ready_end", cfg_ready, 1);
      tick();
      chk("t6_stays_idle", state_dbg, ST_IDLE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
